// File: rtl/jelly_data_player_fifo_pkg.sv
// Shared register map and control/status bit positions for the data player FIFO.
package jelly_data_player_fifo_pkg;

   localparam int ADR_CORE_ID      = 32'h0000_0000;
   localparam int ADR_CORE_VERSION = 32'h0000_0001;
   localparam int ADR_CTL_CONTROL  = 32'h0000_0004;
   localparam int ADR_CTL_STATUS   = 32'h0000_0005;
   localparam int ADR_CTL_FREE     = 32'h0000_0006;
   localparam int ADR_CTL_COUNT    = 32'h0000_0007;
   localparam int ADR_CTL_INTERVAL = 32'h0000_0008;
   localparam int ADR_WRITE_DATA   = 32'h0000_0010;
   localparam int ADR_STG_DATA0    = 32'h0000_0020;
   localparam int STG_COUNT        = 32'd16;

   localparam int CTL_CONTROL_ENABLE = 32'd0;
   localparam int CTL_CONTROL_CLEAR  = 32'd1;

   localparam int CTL_STATUS_EMPTY    = 32'd0;
   localparam int CTL_STATUS_FULL     = 32'd1;
   localparam int CTL_STATUS_OVERFLOW = 32'd2;

endpackage

// File: rtl/jelly_data_player_fifo_core.sv
// Synchronous FIFO with a registered RAM read stage and a valid/ready output register.
module jelly_data_player_fifo_core #(
   parameter int    DATA_WIDTH = 32,
   parameter int    PTR_WIDTH  = 10,
   parameter string RAM_TYPE   = "block"
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_full,
   input  logic                  fetch_enable,
   input  logic                  load_enable,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [PTR_WIDTH:0]    ram_count,
   output logic [PTR_WIDTH+1:0]  data_count
);

   localparam logic [PTR_WIDTH:0] FIFO_DEPTH = {1'b1, {PTR_WIDTH{1'b0}}};

   logic [PTR_WIDTH:0]    wr_ptr_r;
   logic [PTR_WIDTH:0]    rd_ptr_r;
   logic [DATA_WIDTH-1:0] ram_rdata_s;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  rd_valid_r;
   logic [DATA_WIDTH-1:0] m_data_r;
   logic                  m_valid_r;
   logic                  push_s;
   logic                  out_load_s;
   logic                  rd_fill_s;

   assign ram_count  = wr_ptr_r - rd_ptr_r;
   assign s_full     = (ram_count == FIFO_DEPTH);
   assign push_s     = s_valid & ~s_full & ~clear;
   assign out_load_s = load_enable & rd_valid_r & (~m_valid_r | m_ready);
   // The read stage prefetches one word so the output register can refill every cycle.
   assign rd_fill_s  = fetch_enable & (ram_count != '0) & (~rd_valid_r | out_load_s);
   assign data_count = (PTR_WIDTH+2)'(ram_count) + (PTR_WIDTH+2)'(rd_valid_r) + (PTR_WIDTH+2)'(m_valid_r);
   assign m_data     = m_data_r;
   assign m_valid    = m_valid_r;

   generate
      if (RAM_TYPE == "distributed") begin : g_dist
         (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_r [0:(2**PTR_WIDTH)-1];
         // Storage write port
         always_ff @(posedge clk) begin
            if (push_s) mem_r[wr_ptr_r[PTR_WIDTH-1:0]] <= s_data;
         end
         assign ram_rdata_s = mem_r[rd_ptr_r[PTR_WIDTH-1:0]];
      end else begin : g_block
         (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_r [0:(2**PTR_WIDTH)-1];
         // Storage write port
         always_ff @(posedge clk) begin
            if (push_s) mem_r[wr_ptr_r[PTR_WIDTH-1:0]] <= s_data;
         end
         assign ram_rdata_s = mem_r[rd_ptr_r[PTR_WIDTH-1:0]];
      end
   endgenerate

   // Pointers, read stage and output register; clear acts as a synchronous soft reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
         m_data_r   <= '0;
         m_valid_r  <= 1'b0;
      end else if (clear) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
         m_data_r   <= '0;
         m_valid_r  <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + (PTR_WIDTH+1)'(1);
         if (rd_fill_s) begin
            rd_ptr_r   <= rd_ptr_r + (PTR_WIDTH+1)'(1);
            rd_data_r  <= ram_rdata_s;
            rd_valid_r <= 1'b1;
         end else if (out_load_s) begin
            rd_valid_r <= 1'b0;
         end
         if (out_load_s) begin
            m_data_r  <= rd_data_r;
            m_valid_r <= 1'b1;
         end else if (m_valid_r & m_ready) begin
            m_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/jelly_data_player_fifo.sv
// Wishbone-fed stimulus player: staged words are pushed into a FIFO and paced out on a valid/ready stream.
module jelly_data_player_fifo
   import jelly_data_player_fifo_pkg::*;
#(
   parameter int                 WB_ADR_WIDTH     = 8,
   parameter int                 WB_DAT_WIDTH     = 32,
   parameter int                 WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
   parameter logic [WB_DAT_WIDTH-1:0] CORE_ID     = 32'h527a_f002,
   parameter logic [WB_DAT_WIDTH-1:0] CORE_VERSION = 32'h0000_0000,
   parameter int                 DATA_WIDTH       = 32,
   parameter int                 FIFO_PTR_WIDTH   = 10,
   parameter string              FIFO_RAM_TYPE    = "block",
   parameter int                 INTERVAL_WIDTH   = 16,
   parameter logic               INIT_CTL_CONTROL = 1'b0,
   parameter logic [INTERVAL_WIDTH-1:0] INIT_INTERVAL = '0
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
   input  logic                    s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
   input  logic                    s_wb_stb_i,
   output logic                    s_wb_ack_o,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_valid,
   input  logic                    m_ready
);

   localparam logic [FIFO_PTR_WIDTH:0] FIFO_DEPTH = {1'b1, {FIFO_PTR_WIDTH{1'b0}}};
   localparam int DAT_IDX_W = $clog2(WB_DAT_WIDTH);

   logic                      enable_r;
   logic [INTERVAL_WIDTH-1:0] interval_r;
   logic                      overflow_r;
   logic [INTERVAL_WIDTH-1:0] pacing_r;
   logic [INTERVAL_WIDTH-1:0] pacing_next_s;
   logic [WB_DAT_WIDTH-1:0]   stg_r [0:STG_COUNT-1];
   logic [DATA_WIDTH-1:0]     push_data_s;
   logic                      wr_s;
   logic                      clear_s;
   logic                      push_s;
   logic                      stg_hit_s;
   logic [3:0]                stg_idx_s;
   logic                      load_enable_s;
   logic                      full_s;
   logic [FIFO_PTR_WIDTH:0]   ram_count_s;
   logic [FIFO_PTR_WIDTH:0]   free_s;
   logic [FIFO_PTR_WIDTH+1:0] data_count_s;
   logic [2:0]                status_s;
   logic                      unused_sel_s;
   int                        adr_s;

   assign adr_s        = int'(s_wb_adr_i);
   assign wr_s         = s_wb_stb_i & s_wb_we_i & s_wb_sel_i[0];
   assign clear_s      = wr_s & (adr_s == ADR_CTL_CONTROL) & s_wb_dat_i[CTL_CONTROL_CLEAR];
   assign push_s       = wr_s & (adr_s == ADR_WRITE_DATA);
   assign stg_hit_s    = (adr_s >= ADR_STG_DATA0) && (adr_s < ADR_STG_DATA0 + STG_COUNT);
   assign stg_idx_s    = s_wb_adr_i[3:0];
   assign s_wb_ack_o   = s_wb_stb_i;
   assign free_s       = FIFO_DEPTH - ram_count_s;
   assign unused_sel_s = ^s_wb_sel_i;

   // Pushed word: current bus data in the low lane, staging words 1..15 above it
   always_comb begin
      push_data_s = '0;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         if (b < WB_DAT_WIDTH) begin
            push_data_s[b] = s_wb_dat_i[b];
         end else begin
            push_data_s[b] = stg_r[4'(b / WB_DAT_WIDTH)][DAT_IDX_W'(b % WB_DAT_WIDTH)];
         end
      end
   end

   // Pacing counter next value; a load is allowed only when this edge leaves it at zero
   always_comb begin
      pacing_next_s = '0;
      if (m_valid & m_ready) begin
         pacing_next_s = interval_r;
      end else if (pacing_r != '0) begin
         pacing_next_s = pacing_r - INTERVAL_WIDTH'(1);
      end else begin
         pacing_next_s = '0;
      end
   end

   assign load_enable_s = enable_r & (pacing_next_s == '0);

   // Status word assembly
   always_comb begin
      status_s                      = 3'b000;
      status_s[CTL_STATUS_EMPTY]    = (data_count_s == '0);
      status_s[CTL_STATUS_FULL]     = full_s;
      status_s[CTL_STATUS_OVERFLOW] = overflow_r;
   end

   // Combinational register read mux
   always_comb begin
      s_wb_dat_o = '0;
      case (adr_s)
         ADR_CORE_ID:      s_wb_dat_o = CORE_ID;
         ADR_CORE_VERSION: s_wb_dat_o = CORE_VERSION;
         ADR_CTL_CONTROL:  s_wb_dat_o = WB_DAT_WIDTH'(enable_r);
         ADR_CTL_STATUS:   s_wb_dat_o = WB_DAT_WIDTH'(status_s);
         ADR_CTL_FREE:     s_wb_dat_o = WB_DAT_WIDTH'(free_s);
         ADR_CTL_COUNT:    s_wb_dat_o = WB_DAT_WIDTH'(data_count_s);
         ADR_CTL_INTERVAL: s_wb_dat_o = WB_DAT_WIDTH'(interval_r);
         default: begin
            if (stg_hit_s) begin
               s_wb_dat_o = stg_r[stg_idx_s];
            end else begin
               s_wb_dat_o = '0;
            end
         end
      endcase
   end

   // Control, interval, staging, overflow and pacing registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         enable_r   <= INIT_CTL_CONTROL;
         interval_r <= INIT_INTERVAL;
         overflow_r <= 1'b0;
         pacing_r   <= '0;
         for (int i = 0; i < STG_COUNT; i++) stg_r[i] <= '0;
      end else begin
         if (wr_s && adr_s == ADR_CTL_CONTROL) enable_r <= s_wb_dat_i[CTL_CONTROL_ENABLE];
         if (wr_s && adr_s == ADR_CTL_INTERVAL) interval_r <= s_wb_dat_i[INTERVAL_WIDTH-1:0];
         if (wr_s && stg_hit_s) stg_r[stg_idx_s] <= s_wb_dat_i;
         if (wr_s && adr_s == ADR_CTL_FREE) begin
            overflow_r <= 1'b0;
         end else if (push_s & full_s & ~clear_s) begin
            overflow_r <= 1'b1;
         end
         pacing_r <= clear_s ? '0 : pacing_next_s;
      end
   end

   jelly_data_player_fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .PTR_WIDTH  (FIFO_PTR_WIDTH),
      .RAM_TYPE   (FIFO_RAM_TYPE)
   ) u_core (
      .clk          (aclk),
      .rst_n        (aresetn),
      .clear        (clear_s),
      .s_data       (push_data_s),
      .s_valid      (push_s),
      .s_full       (full_s),
      .fetch_enable (enable_r),
      .load_enable  (load_enable_s),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .ram_count    (ram_count_s),
      .data_count   (data_count_s)
   );

endmodule
